exec_dispatch_unit: RTL and testbench
=====================================

EXEC_DISPATCH_UNIT -- requirements
Module: exec_dispatch_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the WAIT-state cycle limit used when EXEC_TIMEOUT_EN is defined.
REQ-002 SHALL use one clock and an asynchronous, active-high reset; clock and reset port names follow the codebase.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  upstream instruction valid.
REQ-006 in_ready  output  1  dispatcher can accept an instruction.
REQ-007 in_pc  input  32  instruction address.
REQ-008 in_inst  input  32  raw instruction word.
REQ-009 rf_raddr0, rf_raddr1  output  5 each  register-file read addresses (rs, rt fields).
REQ-010 rf_rdata0, rf_rdata1  input  32 each  combinational register-file read data.
REQ-011 el_reset  output  1  exec element reset/start.
REQ-012 el_completed  input  1  exec element done.
REQ-013 el_pc, el_inst_num, el_const16, el_const16_x, el_shift5, el_addr26, el_rs, el_rt  output  32/6/16/32/5/26/32/32  held operands to the element.
REQ-014 el_out  input  32  element result.
REQ-015 wb_valid  output  1  writeback request.
REQ-016 wb_ready  input  1  writeback accepts.
REQ-017 wb_we, wb_addr, wb_data, wb_pc, wb_err  output  1/5/32/32/1  write enable, destination, result, pc, timeout flag.

Function
REQ-018 Field decode: inst_num=inst[31:26], rs idx=[25:21], rt idx=[20:16], rd idx=[15:11], shift5=[10:6], const16=[15:0], const16_x=sign-extend of const16, addr26=[25:0].
REQ-019 rf_raddr0/1 SHALL be driven combinationally from in_inst rs/rt fields at all times.
REQ-020 FSM states IDLE, START, WAIT, RESULT; in_ready=1 only in IDLE.
REQ-021 IDLE: on in_valid, latch pc, decoded fields, rf_rdata0/1 and destination, then go to START.
REQ-022 START: el_reset=1 for exactly one cycle, then go to WAIT; el_reset=0 in all other states except during reset.
REQ-023 WAIT: on el_completed=1, latch el_out into wb_data, then go to RESULT.
REQ-024 RESULT: wb_valid=1; hold all wb_* stable until the wb_ready edge, then go to IDLE.
REQ-025 Latency: with the element completing on its first non-reset edge, wb_valid SHALL rise after the 3rd rising edge following acceptance.
REQ-026 Destination: rt for inst_num 9, 11, 21, 23, 25; rd for other ALU codes (8-13, 16-18, 20, 22, 24, 26).
REQ-027 wb_we=1 only for ALU codes with destination != 0; other codes complete with wb_we=0.
REQ-028 el_* outputs SHALL remain stable from START through RESULT.
REQ-029 No overlap: a new instruction SHALL NOT be accepted in the cycle wb_ready completes; one bubble cycle minimum.

Reset
REQ-030 Asynchronous reset SHALL force IDLE from any state, mid-operation included, and discard any held instruction.
REQ-031 Reset values: in_ready=1 after release, el_reset=1 while reset is asserted, wb_valid=0, wb_we=0, wb_err=0, all data/address outputs 0.

Configuration
REQ-032 With EXEC_TIMEOUT_EN defined, a WAIT cycle counter SHALL run; reaching TIMEOUT_CYCLES without el_completed SHALL enter RESULT with wb_err=1, wb_we=0, wb_data=0.
REQ-033 Without EXEC_TIMEOUT_EN, WAIT SHALL be unbounded, no counter SHALL exist, and wb_err SHALL be tied 0.

Structure
REQ-034 Shared package felis_exec_pkg SHALL hold the FSM state enum, inst_num constants, instruction field bit positions and the is-ALU/uses-rt-dest classification.
REQ-035 Combinational field extraction SHALL be a sub-module exec_field_decode; the FSM, latches and counter stay in the top module.

Verification
REQ-036 ADD r3=r1+r2, rf_rdata 5/7, element completes at first edge -> wb_valid 3 edges after accept, wb_addr=3, wb_data=el_out, wb_we=1.
REQ-037 ADDI with rt=0 -> wb_valid asserted with wb_we=0.
REQ-038 wb_ready held low for 10 cycles in RESULT -> wb_* stable and in_ready=0 throughout; IDLE on the ready edge.
REQ-039 reset asserted while in WAIT -> IDLE, wb_valid=0 and el_reset=1 immediately; next instruction is processed normally.
REQ-040 EXEC_TIMEOUT_EN with TIMEOUT_CYCLES=4 and el_completed never rising -> wb_err=1, wb_we=0 after 4 WAIT cycles.
REQ-041 inst_num 63 (non-ALU) -> completes with wb_we=0, wb_err=0.

Source files
------------

// File: rtl/felis_exec_pkg.sv
// Shared types for the execute dispatcher: FSM states, instruction field positions,
// inst_num constants and the ALU / rt-destination classification.
package felis_exec_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_WAIT   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam int NUM_HI  = 31;
    localparam int NUM_LO  = 26;
    localparam int RS_HI   = 25;
    localparam int RS_LO   = 21;
    localparam int RT_HI   = 20;
    localparam int RT_LO   = 16;
    localparam int RD_HI   = 15;
    localparam int RD_LO   = 11;
    localparam int SH_HI   = 10;
    localparam int SH_LO   = 6;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;
    localparam int ADDR_HI = 25;
    localparam int ADDR_LO = 0;

    localparam logic [5:0] INST_ADD     = 6'd8;
    localparam logic [5:0] INST_ADDI    = 6'd9;
    localparam logic [5:0] INST_ALU_MAX = 6'd26;

    function automatic logic is_alu(input logic [5:0] num);
        return num inside {[6'd8:6'd13], [6'd16:6'd18], [6'd20:INST_ALU_MAX]};
    endfunction

    // Immediate-form ALU codes write rt; the rest of the ALU codes write rd.
    function automatic logic uses_rt_dest(input logic [5:0] num);
        return num inside {6'd9, 6'd11, 6'd21, 6'd23, 6'd25};
    endfunction

endpackage

// File: rtl/exec_field_decode.sv
// Pure combinational split of a raw instruction word into its operand fields.
module exec_field_decode
    import felis_exec_pkg::*;
(
    input  logic [31:0] inst,
    output logic [5:0]  inst_num,
    output logic [4:0]  rs_idx,
    output logic [4:0]  rt_idx,
    output logic [4:0]  rd_idx,
    output logic [4:0]  shift5,
    output logic [15:0] const16,
    output logic [31:0] const16_x,
    output logic [25:0] addr26
);

    assign inst_num  = inst[NUM_HI:NUM_LO];
    assign rs_idx    = inst[RS_HI:RS_LO];
    assign rt_idx    = inst[RT_HI:RT_LO];
    assign rd_idx    = inst[RD_HI:RD_LO];
    assign shift5    = inst[SH_HI:SH_LO];
    assign const16   = inst[IMM_HI:IMM_LO];
    assign const16_x = {{16{inst[IMM_HI]}}, inst[IMM_HI:IMM_LO]};
    assign addr26    = inst[ADDR_HI:ADDR_LO];

endmodule

// File: rtl/exec_dispatch_unit.sv
// Single-issue dispatcher: latches one instruction, starts the exec element, waits, writes back.
// Define EXEC_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES and report wb_err.
module exec_dispatch_unit
    import felis_exec_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic [4:0]  rf_raddr0,
    output logic [4:0]  rf_raddr1,
    input  logic [31:0] rf_rdata0,
    input  logic [31:0] rf_rdata1,
    output logic        el_reset,
    input  logic        el_completed,
    output logic [31:0] el_pc,
    output logic [5:0]  el_inst_num,
    output logic [15:0] el_const16,
    output logic [31:0] el_const16_x,
    output logic [4:0]  el_shift5,
    output logic [25:0] el_addr26,
    output logic [31:0] el_rs,
    output logic [31:0] el_rt,
    input  logic [31:0] el_out,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [31:0] wb_pc,
    output logic        wb_err,
    output state_t      dbg_state
);

    // Handshakes (in_*, wb_*): a transfer happens on a rising edge where valid && ready are
    // both high; the payload must be stable while valid is high, and ready never depends
    // combinationally on valid.

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state;
    logic        el_start;
    logic [5:0]  dec_inst_num;
    logic [4:0]  dec_rs, dec_rt, dec_rd, dec_shift5;
    logic [15:0] dec_const16;
    logic [31:0] dec_const16_x;
    logic [25:0] dec_addr26;
    logic [4:0]  dest_idx;
    logic        dest_we;

    exec_field_decode u_decode (
        .inst      (in_inst),
        .inst_num  (dec_inst_num),
        .rs_idx    (dec_rs),
        .rt_idx    (dec_rt),
        .rd_idx    (dec_rd),
        .shift5    (dec_shift5),
        .const16   (dec_const16),
        .const16_x (dec_const16_x),
        .addr26    (dec_addr26)
    );

    assign rf_raddr0 = dec_rs;
    assign rf_raddr1 = dec_rt;

    // Non-ALU codes have no destination, so they report address 0 and never write.
    assign dest_idx  = !is_alu(dec_inst_num) ? 5'd0 :
                       (uses_rt_dest(dec_inst_num) ? dec_rt : dec_rd);
    assign dest_we   = is_alu(dec_inst_num) && (dest_idx != 5'd0);

    // The element is held in reset whenever the dispatcher is, not only during START.
    assign el_reset  = reset | el_start;
    assign dbg_state = state;

`ifdef EXEC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] wait_cnt;
    logic          err_q;
    assign wb_err = err_q;
`else
    assign wb_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            in_ready     <= 1'b1;
            wb_valid     <= 1'b0;
            el_start     <= 1'b0;
            el_pc        <= '0;
            el_inst_num  <= '0;
            el_const16   <= '0;
            el_const16_x <= '0;
            el_shift5    <= '0;
            el_addr26    <= '0;
            el_rs        <= '0;
            el_rt        <= '0;
            wb_we        <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            wb_pc        <= '0;
`ifdef EXEC_TIMEOUT_EN
            wait_cnt     <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        el_pc        <= in_pc;
                        el_inst_num  <= dec_inst_num;
                        el_const16   <= dec_const16;
                        el_const16_x <= dec_const16_x;
                        el_shift5    <= dec_shift5;
                        el_addr26    <= dec_addr26;
                        el_rs        <= rf_rdata0;
                        el_rt        <= rf_rdata1;
                        wb_pc        <= in_pc;
                        wb_addr      <= dest_idx;
                        wb_we        <= dest_we;
                        wb_data      <= '0;
                        in_ready     <= 1'b0;
                        el_start     <= 1'b1;
                        state        <= S_START;
`ifdef EXEC_TIMEOUT_EN
                        err_q        <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    el_start <= 1'b0;
                    state    <= S_WAIT;
`ifdef EXEC_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (el_completed) begin
                        wb_data  <= el_out;
                        wb_valid <= 1'b1;
                        state    <= S_RESULT;
                    end
`ifdef EXEC_TIMEOUT_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        err_q    <= 1'b1;
                        wb_we    <= 1'b0;
                        wb_data  <= '0;
                        wb_valid <= 1'b1;
                        state    <= S_RESULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_RESULT: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_dispatch_unit.sv
// Directed bench for exec_dispatch_unit with a register-file model, a simple exec element
// model and a writeback scoreboard; define EXEC_TIMEOUT_EN to also cover the timeout path.
module tb_exec_dispatch_unit;
    import felis_exec_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [4:0]  rf_raddr0, rf_raddr1;
    logic [31:0] rf_rdata0, rf_rdata1;
    logic        el_reset;
    logic        el_completed = 1'b0;
    logic [31:0] el_pc;
    logic [5:0]  el_inst_num;
    logic [15:0] el_const16;
    logic [31:0] el_const16_x;
    logic [4:0]  el_shift5;
    logic [25:0] el_addr26;
    logic [31:0] el_rs, el_rt;
    logic [31:0] el_out;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic        wb_err;
    state_t      dbg_state;

    exec_dispatch_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
        .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
        .el_reset(el_reset), .el_completed(el_completed),
        .el_pc(el_pc), .el_inst_num(el_inst_num), .el_const16(el_const16),
        .el_const16_x(el_const16_x), .el_shift5(el_shift5), .el_addr26(el_addr26),
        .el_rs(el_rs), .el_rt(el_rt), .el_out(el_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_pc(wb_pc), .wb_err(wb_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Register file and exec element models.
    logic [31:0] rf [32];
    assign rf_rdata0 = rf[rf_raddr0];
    assign rf_rdata1 = rf[rf_raddr1];
    assign el_out    = el_rs + el_rt;

    int el_delay = 0;
    bit el_hang  = 1'b0;
    int el_cnt   = 0;
    always @(posedge clk) begin
        if (el_reset) begin
            el_cnt       <= 0;
            el_completed <= 1'b0;
        end else if (!el_hang) begin
            if (el_cnt == el_delay) el_completed <= 1'b1;
            else                    el_cnt <= el_cnt + 1;
        end
    end

    logic [70:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mk_inst(input logic [5:0] num, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [15:0] imm);
        return {num, rs, rt, imm};
    endfunction

    // Expected writeback {we, addr, data, pc, err}.
    function automatic logic [70:0] m_wb(input logic [31:0] inst, input logic [31:0] pc,
                                         input bit hang);
        logic [5:0]  n;
        logic [4:0]  rs, rt, rd, dst;
        logic        alu, rt_dest, we, err;
        logic [31:0] data;
        n   = inst[31:26];
        rs  = inst[25:21];
        rt  = inst[20:16];
        rd  = inst[15:11];
        alu = (n >= 6'd8 && n <= 6'd13) || (n >= 6'd16 && n <= 6'd18) ||
              (n >= 6'd20 && n <= 6'd26);
        rt_dest = (n == 6'd9) || (n == 6'd11) || (n == 6'd21) || (n == 6'd23) || (n == 6'd25);
        dst  = !alu ? 5'd0 : (rt_dest ? rt : rd);
        we   = alu && (dst != 5'd0);
        data = rf[rs] + rf[rt];
        err  = 1'b0;
        if (hang) begin
            we   = 1'b0;
            data = 32'd0;
            err  = 1'b1;
        end
        return {we, dst, data, pc, err};
    endfunction

    function automatic logic [180:0] m_el(input logic [31:0] inst, input logic [31:0] pc);
        logic [4:0] rs, rt;
        rs = inst[25:21];
        rt = inst[20:16];
        return {pc, inst[31:26], inst[15:0], {{16{inst[15]}}, inst[15:0]}, inst[10:6],
                inst[25:0], rf[rs], rf[rt]};
    endfunction

    function automatic logic [180:0] dut_el();
        return {el_pc, el_inst_num, el_const16, el_const16_x, el_shift5, el_addr26, el_rs, el_rt};
    endfunction

    function automatic logic [70:0] dut_wb();
        return {wb_we, wb_addr, wb_data, wb_pc, wb_err};
    endfunction

    // Drive one instruction, wait for its writeback, optionally stall wb_ready for `hold` cycles.
    task automatic run_inst(input logic [31:0] inst, input logic [31:0] pc,
                            input int exp_lat, input int hold);
        logic [70:0]  exp;
        logic [180:0] exp_el;
        int lat;
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        #1;
        check("rf_raddr", {rf_raddr0, rf_raddr1}, {inst[25:21], inst[20:16]});
        exp_q.push_back(m_wb(inst, pc, el_hang));
        exp_el = m_el(inst, pc);
        tick();
        in_valid = 1'b0;
        check("el_reset_start", {el_reset, in_ready}, 2'b10);
        check("el_ops_start", dut_el(), exp_el);
        lat = 0;
        while (!wb_valid && lat < 200) begin
            tick();
            lat++;
            if (lat == 1) check("el_reset_low_wait", el_reset, 0);
        end
        check("wb_valid_seen", wb_valid, 1);
        if (exp_lat >= 0) check("latency", lat, exp_lat);
        exp = exp_q.pop_front();
        check("wb_fields", dut_wb(), exp);
        check("el_ops_result", dut_el(), exp_el);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_wb", {wb_valid, in_ready, dut_wb()}, {1'b1, 1'b0, exp});
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("idle_after_ready", {in_ready, wb_valid, el_reset}, 3'b100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  nums [16];
        logic [5:0]  n;
        logic [31:0] inst;
        nums = '{6'd8, 6'd10, 6'd12, 6'd13, 6'd16, 6'd17, 6'd18, 6'd20,
                 6'd21, 6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd5, 6'd40};
        rf[0] = 32'd0;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        for (int i = 3; i < 32; i++) rf[i] = $urandom;

        // Reset behaviour.
        reset    = 1'b1;
        in_valid = 1'b0;
        in_pc    = 32'd0;
        in_inst  = 32'd0;
        wb_ready = 1'b0;
        tick();
        tick();
        check("rst_hold", {el_reset, wb_valid, in_ready}, 3'b101);
        check("rst_state", dbg_state, S_IDLE);
        reset = 1'b0;
        #1;
        check("rst_release_ctl", {in_ready, el_reset, wb_valid}, 3'b100);
        check("rst_wb_zero", dut_wb(), 71'd0);
        check("rst_el_zero", dut_el(), 181'd0);
        tick();

        // ADD r3 = r1 + r2, element completes on its first non-reset edge.
        run_inst(mk_inst(INST_ADD, 5'd1, 5'd2, 16'h1800), 32'h0000_1000, 3, 0);
        // ADDI-style rt destination with rt = 0: completes without a write.
        run_inst(mk_inst(INST_ADDI, 5'd1, 5'd0, 16'h1805), 32'h0000_1004, 3, 0);
        // Writeback stalled for 10 cycles.
        el_delay = 1;
        run_inst(mk_inst(6'd10, 5'd2, 5'd1, 16'h2000), 32'h0000_1008, 4, 10);
        el_delay = 0;
        // Non-ALU code.
        run_inst(mk_inst(6'd63, 5'd4, 5'd5, 16'h3000), 32'h0000_100c, 3, 0);
        // Negative immediate to exercise sign extension on an rt-destination code.
        run_inst(mk_inst(6'd21, 5'd6, 5'd7, 16'h8001), 32'h0000_1010, 3, 1);

        // Reset while waiting on the element.
        el_hang  = 1'b1;
        in_valid = 1'b1;
        in_inst  = mk_inst(INST_ADD, 5'd1, 5'd2, 16'h1800);
        in_pc    = 32'h0000_2000;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("state_wait", dbg_state, S_WAIT);
        reset = 1'b1;
        #1;
        check("rst_mid_ctl", {wb_valid, el_reset, in_ready}, 3'b011);
        check("rst_mid_state", dbg_state, S_IDLE);
        tick();
        reset   = 1'b0;
        el_hang = 1'b0;
        tick();
        run_inst(mk_inst(INST_ADD, 5'd1, 5'd2, 16'h1800), 32'h0000_2004, 3, 0);

        // Randomised mix of codes, registers and element delays.
        for (int k = 0; k < 8; k++) begin
            n        = nums[$urandom_range(0, 15)];
            inst     = {n, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                        16'($urandom)};
            el_delay = $urandom_range(0, 1);
            run_inst(inst, 32'h0000_3000 + 32'(k * 4), 3 + el_delay, $urandom_range(0, 2));
        end
        el_delay = 0;

`ifdef EXEC_TIMEOUT_EN
        // Element never completes: one START cycle plus four WAIT cycles.
        el_hang = 1'b1;
        run_inst(mk_inst(INST_ADD, 5'd1, 5'd2, 16'h1800), 32'h0000_4000, 5, 2);
        el_hang = 1'b0;
        run_inst(mk_inst(INST_ADD, 5'd1, 5'd2, 16'h1800), 32'h0000_4004, 3, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
